flash_loader_ctrl: RTL

Boot/flash controller that sequences instruction-memory loading from the UART receiver. It consumes a length-prefixed little-endian byte stream and assembles it into 32-bit words. It writes those words into instruction memory from address 0 while holding the pipeline. It then pulses a PC reset and releases the core. It sits between uart_interface and the fetch-stage instruction memory, and replaces the ad-hoc flash handling in fetch.

---
 rtl/flash_loader_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/flash_loader_ctrl.sv
// Boot loader: assembles a length-prefixed little-endian UART byte stream into
// 32-bit words, writes them to imem from address 0 while holding the core, then pulses PC reset.
module flash_loader_ctrl #(
  parameter int IMEM_WORDS     = 256,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flash,
  input  logic                  uart_received,
  input  logic [7:0]            uart_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  pc_reset,
  output logic                  busy,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR} state_t;

  state_t        state, state_n;
  logic          flash_q;
  logic [15:0]   len;
  logic [1:0]    byte_idx;
  logic [31:0]   word;
  logic [TW-1:0] tmo;

  logic        start, active, timed_out, last_word;
  logic [15:0] len_full;

  assign start     = flash & ~flash_q;
  assign active    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == WRITE);
  assign timed_out = active && !uart_received && (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign len_full  = {uart_data, len[7:0]};
  // words_loaded doubles as the write address; it always equals the word index.
  assign last_word = (words_loaded + 16'd1) == len;

  always_comb begin
    state_n = state;
    if (start)
      state_n = LEN_LO;
    else if (timed_out)
      state_n = ERROR;
    else begin
      case (state)
        LEN_LO: if (uart_received) state_n = LEN_HI;
        LEN_HI: if (uart_received) begin
          if (len_full == 16'd0)                        state_n = DONE;
          else if ({16'd0, len_full} > 32'(IMEM_WORDS)) state_n = ERROR;
          else                                          state_n = DATA;
        end
        DATA:   if (uart_received && byte_idx == 2'd3) state_n = WRITE;
        WRITE:  state_n = last_word ? DONE : DATA;
        DONE:   state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      flash_q      <= 1'b1;
      len          <= '0;
      byte_idx     <= '0;
      word         <= '0;
      tmo          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b0;
      pc_reset     <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      flash_q  <= flash;
      state    <= state_n;
      imem_we  <= (state_n == WRITE);
      cpu_hold <= (state_n != IDLE);
      pc_reset <= (state_n == DONE);
      busy     <= (state_n != IDLE) && (state_n != ERROR);
      error    <= (state_n == ERROR);

      if (start || uart_received || !active) tmo <= '0;
      else                                   tmo <= tmo + TW'(1);

      if (start) begin
        len          <= '0;
        byte_idx     <= '0;
        word         <= '0;
        words_loaded <= '0;
      end else begin
        case (state)
          LEN_LO: if (uart_received) len[7:0] <= uart_data;
          LEN_HI: if (uart_received) begin
            len[15:8]    <= uart_data;
            byte_idx     <= '0;
            words_loaded <= '0;
          end
          DATA: if (uart_received) begin
            word[8*byte_idx +: 8] <= uart_data;
            byte_idx              <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
              imem_wdata <= {uart_data, word[23:0]};
            end
          end
          WRITE: begin
            words_loaded <= words_loaded + 16'd1;
            // A byte landing during the write cycle starts the next word.
            if (uart_received && !last_word) begin
              word[7:0] <= uart_data;
              byte_idx  <= 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
